// File: rtl/seg7_capture.sv
// Observes a multiplexed active-low 7-segment display, waits for a stable
// sample window, and decodes the displayed hex digits into a 16-bit value.
module seg7_capture #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err_pat,
  output logic        err_sel
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE);
  localparam logic [7:0] STABLE_M1  = 8'(STABLE - 1);

  logic [10:0] s1;
  logic [10:0] s;
  logic [10:0] s_prev;
  logic [7:0]  cnt;

  // NOTE: all-ones is the blank display, so the pipeline comes out of reset
  // looking like an idle bus and no digit can be captured from reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= '1;
      s      <= '1;
      s_prev <= '1;
    end else begin
      s1     <= {dig_sel, seg_in};
      s      <= s1;
      s_prev <= s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (s != s_prev) begin
      cnt <= '0;
    end else if (cnt != STABLE_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Saturation of cnt at STABLE makes this true for exactly one cycle per episode.
  logic capture;
  assign capture = (cnt == STABLE_M1) && (s == s_prev);

  logic [3:0] sel_n;
  logic       sel_one;
  logic       sel_multi;
  assign sel_n     = ~s[10:7];
  assign sel_multi = (sel_n & (sel_n - 4'd1)) != 4'd0;
  assign sel_one   = (sel_n != 4'd0) && !sel_multi;

  logic [1:0] idx;
  logic [3:0] nib;
  logic       hit;

  // NOTE: every signal gets a default before the case/loop so no latch is inferred.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_n[i]) idx = 2'(i);
    end
  end

  always_comb begin
    hit = 1'b1;
    nib = '0;
    case (s[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments, later ones win: the clr branch sits last
  // so it overrides flag updates from a same-cycle capture but not value/upd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value       <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      err_pat     <= 1'b0;
      err_sel     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (capture && sel_multi) begin
        err_sel <= 1'b1;
      end
      if (capture && sel_one) begin
        if (hit) begin
          value[idx*4 +: 4] <= nib;
          digit_valid[idx]  <= 1'b1;
          upd               <= 1'b1;
          upd_idx           <= idx;
        end else begin
          err_pat          <= 1'b1;
          digit_valid[idx] <= 1'b0;
        end
      end
      if (clr) begin
        err_pat     <= 1'b0;
        err_sel     <= 1'b0;
        digit_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: run-length reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_seg7_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_sel = 4'hF;
  logic        clr = 1'b0;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        err_pat;
  logic        err_sel;

  seg7_capture #(.STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .clr(clr),
    .value(value), .digit_valid(digit_valid), .upd(upd), .upd_idx(upd_idx),
    .err_pat(err_pat), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the display table and a run-length view of the synchronized stream.
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [10:0] m_s1 = '1;
  logic [10:0] m_last = '1;
  int          m_run = 2;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dv = '0;
  logic        m_upd = 1'b0;
  logic [1:0]  m_idx = '0;
  logic        m_ep = 1'b0;
  logic        m_es = 1'b0;
  logic [3:0]  m_d;
  int          m_n;
  int          m_nib;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '1; m_last = '1; m_run = 2;
      m_val = '0; m_dv = '0; m_upd = 1'b0; m_idx = '0; m_ep = 1'b0; m_es = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (m_run == STABLE + 1) begin
        m_d = m_last[10:7];
        if ($countones(m_d) <= 2) begin
          m_es = 1'b1;
        end else if ($countones(m_d) == 3) begin
          m_n = 0;
          for (int i = 0; i < 4; i++) if (!m_d[i]) m_n = i;
          m_nib = -1;
          for (int j = 0; j < 16; j++) if (tbl[j] == m_last[6:0]) m_nib = j;
          if (m_nib >= 0) begin
            m_val[m_n*4 +: 4] = 4'(m_nib);
            m_dv[m_n] = 1'b1;
            m_upd = 1'b1;
            m_idx = 2'(m_n);
          end else begin
            m_ep = 1'b1;
            m_dv[m_n] = 1'b0;
          end
        end
      end
      if (clr) begin
        m_ep = 1'b0; m_es = 1'b0; m_dv = '0;
      end
      if (m_s1 == m_last) begin
        if (m_run < 1000) m_run = m_run + 1;
      end else begin
        m_run = 1;
      end
      m_last = m_s1;
      m_s1 = {dig_sel, seg_in};
    end
  end

  int upd_seen = 0;
  always @(negedge clk) begin
    check("outputs_vs_model",
          {7'd0, value, digit_valid, upd, upd_idx, err_pat, err_sel},
          {7'd0, m_val, m_dv, m_upd, m_idx, m_ep, m_es});
    if (upd) upd_seen++;
  end

  // Inputs change 2 time units after a rising edge; caller stays in that phase.
  task automatic hold(input logic [6:0] sg, input logic [3:0] dg, input int n);
    seg_in = sg;
    dig_sel = dg;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // Holds the inputs and returns the first edge (0-based) after which upd is seen.
  task automatic hold_latency(input logic [6:0] sg, input logic [3:0] dg, input int n,
                              output int first);
    first = -1;
    seg_in = sg;
    dig_sel = dg;
    for (int e = 0; e < n; e++) begin
      @(posedge clk); #2;
      if (upd && first < 0) first = e;
    end
  endtask

  int base;
  int first;

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset_outputs", {value, digit_valid, upd, upd_idx, err_pat, err_sel}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    hold(7'h7F, 4'hF, 8);

    // Single digit 0 showing "2", with latency measurement.
    base = upd_seen;
    hold_latency(7'h24, 4'b1110, 10, first);
    check("latency_edges", first, 6);
    check("d0_upd_count", upd_seen - base, 1);
    check("d0_upd_idx", upd_idx, 0);
    check("d0_value", value, 16'h0002);
    check("d0_valid", digit_valid, 4'b0001);

    // Four digits scanned.
    base = upd_seen;
    hold(7'h30, 4'b1110, 8);
    hold(7'h19, 4'b1101, 8);
    hold(7'h12, 4'b1011, 8);
    hold(7'h46, 4'b0111, 8);
    check("scan_upd_count", upd_seen - base, 4);
    check("scan_value", value, 16'hC543);
    check("scan_valid", digit_valid, 4'b1111);
    check("model_pin_value", m_val, 16'hC543);
    check("scan_last_idx", upd_idx, 3);

    // Unknown pattern on digit 1.
    base = upd_seen;
    hold(7'h7F, 4'b1101, 8);
    check("badpat_err", err_pat, 1);
    check("badpat_valid", digit_valid, 4'b1101);
    check("badpat_value", value, 16'hC543);
    check("badpat_no_upd", upd_seen - base, 0);

    // Two digits enabled together, then clear.
    base = upd_seen;
    hold(7'h40, 4'b1100, 8);
    check("multisel_err", err_sel, 1);
    check("multisel_no_upd", upd_seen - base, 0);
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    check("clr_err_sel", err_sel, 0);
    check("clr_err_pat", err_pat, 0);
    check("clr_valid", digit_valid, 4'b0000);

    // clr coincident with a table hit: value written, upd pulses, flags stay clear.
    seg_in = 7'h02;
    dig_sel = 4'b1011;
    for (int e = 0; e < 10; e++) begin
      clr = (e == 6);
      @(posedge clk); #2;
      if (e == 6) begin
        check("clrhit_upd", upd, 1);
        check("clrhit_value", value, 16'hC643);
        check("clrhit_valid", digit_valid, 4'b0000);
      end
    end
    clr = 1'b0;

    // Pattern toggled every 3 cycles never captures.
    base = upd_seen;
    for (int k = 0; k < 10; k++) hold((k % 2) ? 7'h30 : 7'h19, 4'b1110, 3);
    check("toggle_no_upd", upd_seen - base, 0);
    check("toggle_flags", {err_pat, err_sel}, 2'b00);

    // Reset mid-window, then a full window is needed again.
    hold(7'h79, 4'b1110, 3);
    rst = 1'b0;
    #1;
    check("midrst_outputs", {value, digit_valid, upd, upd_idx, err_pat, err_sel}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    hold_latency(7'h79, 4'b1110, 10, first);
    check("postrst_latency", first, 6);
    check("postrst_value", value, 16'h0001);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 300; ep++) begin
      logic [6:0] sg;
      logic [3:0] dg;
      int len;
      case ($urandom_range(0, 5))
        0: dg = 4'b1110;
        1: dg = 4'b1101;
        2: dg = 4'b1011;
        3: dg = 4'b0111;
        4: dg = 4'b1111;
        default: dg = 4'($urandom);
      endcase
      sg = ($urandom_range(0, 3) != 0) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
      len = $urandom_range(1, 9);
      seg_in = sg;
      dig_sel = dg;
      for (int c = 0; c < len; c++) begin
        clr = ($urandom_range(0, 15) == 0);
        @(posedge clk); #2;
      end
      clr = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
      end
    end

    hold(7'h7F, 4'hF, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
